// File: rtl/lc3b_types.sv
// Shared LC-3b types: pmem line type, beat count and the pmem responder FSM states.
package lc3b_types;

    typedef logic [127:0] lc3b_pmem_line;

    localparam int PMEM_BEATS  = 8;
    localparam int PMEM_WORD_W = 16;

    typedef enum logic [2:0] {
        PMEM_IDLE,
        PMEM_BURST,
        PMEM_DRAIN,
        PMEM_WAIT,
        PMEM_RESP
    } pmem_state_e;

endpackage

// File: rtl/pmem_line_responder_array.sv
// Word-wide single-port storage behind the line responder; synchronous write,
// registered read with one cycle of latency. Contents are never reset.
module pmem_word_array #(
    parameter int DEPTH_WORDS = 32768,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem [DEPTH_WORDS];
    logic [15:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/pmem_line_responder.sv
// Cycle-accurate pmem responder: one 128-bit line per request, serviced as eight
// 16-bit beats plus LATENCY wait cycles. Optional checker: PMEM_PROTOCOL_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for pmem_read/pmem_write; request latched here
// BURST | eight beats against the word array, beat counter 0..7
// DRAIN | last read word returns from the array
// WAIT  | LATENCY down-count
// RESP  | one-cycle pmem_resp pulse
module pmem_line_responder
    import lc3b_types::*;
#(
    parameter int LATENCY     = 10,
    parameter int DEPTH_LINES = 4096
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pmem_read,
    input  logic          pmem_write,
    input  logic [15:0]   pmem_address,
    input  lc3b_pmem_line pmem_wdata,
    output lc3b_pmem_line pmem_rdata,
    output logic          pmem_resp,
    output logic          pmem_err
);

    localparam int IDX_W = $clog2(DEPTH_LINES);
    localparam int AW    = IDX_W + 3;

    pmem_state_e      state_q, state_d;
    logic [2:0]       beat_q, beat_d;
    logic [7:0]       wait_q, wait_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             op_wr_q, op_wr_d;
    lc3b_pmem_line    wdata_q, wdata_d;
    lc3b_pmem_line    asm_q, asm_d;
    lc3b_pmem_line    rdata_q, rdata_d;

    logic             arr_en;
    logic             arr_we;
    logic [AW-1:0]    arr_addr;
    logic [15:0]      arr_wdata;
    logic [15:0]      arr_rdata;
    logic             req;
    logic             unused_addr;

    assign req         = pmem_read | pmem_write;
    assign unused_addr = ^pmem_address;

    pmem_word_array #(
        .DEPTH_WORDS (DEPTH_LINES * PMEM_BEATS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .en    (arr_en),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        wait_d    = wait_q;
        idx_d     = idx_q;
        op_wr_d   = op_wr_q;
        wdata_d   = wdata_q;
        asm_d     = asm_q;
        rdata_d   = rdata_q;
        arr_en    = 1'b0;
        arr_we    = 1'b0;
        arr_addr  = {idx_q, beat_q};
        arr_wdata = wdata_q[PMEM_WORD_W*int'(beat_q) +: PMEM_WORD_W];

        case (state_q)
            PMEM_IDLE: begin
                if (req) begin
                    idx_d   = pmem_address[4 +: IDX_W];
                    op_wr_d = pmem_write;
                    wdata_d = pmem_wdata;
                    beat_d  = 3'd0;
                    state_d = PMEM_BURST;
                end
            end
            PMEM_BURST: begin
                arr_en = 1'b1;
                arr_we = op_wr_q;
                // Array read data lags the issued address by one beat.
                if (!op_wr_q && beat_q != 3'd0) begin
                    asm_d[PMEM_WORD_W*(int'(beat_q)-1) +: PMEM_WORD_W] = arr_rdata;
                end
                beat_d = beat_q + 3'd1;
                if (beat_q == 3'd7) begin
                    state_d = PMEM_DRAIN;
                end
            end
            PMEM_DRAIN: begin
                if (!op_wr_q) begin
                    asm_d[127:112] = arr_rdata;
                end
                if (LATENCY == 0) begin
                    state_d = PMEM_RESP;
                end else begin
                    wait_d  = 8'(LATENCY - 1);
                    state_d = PMEM_WAIT;
                end
            end
            PMEM_WAIT: begin
                if (wait_q == 8'd0) begin
                    state_d = PMEM_RESP;
                end else begin
                    wait_d = wait_q - 8'd1;
                end
            end
            PMEM_RESP: begin
                state_d = PMEM_IDLE;
            end
            default: begin
                state_d = PMEM_IDLE;
            end
        endcase

        // asm_d already holds word 7 when DRAIN goes straight to RESP.
        if (state_d == PMEM_RESP && state_q != PMEM_RESP && !op_wr_q) begin
            rdata_d = asm_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PMEM_IDLE;
            beat_q  <= 3'd0;
            wait_q  <= 8'd0;
            idx_q   <= '0;
            op_wr_q <= 1'b0;
            wdata_q <= '0;
            asm_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
            idx_q   <= idx_d;
            op_wr_q <= op_wr_d;
            wdata_q <= wdata_d;
            asm_q   <= asm_d;
            rdata_q <= rdata_d;
        end
    end

    assign pmem_rdata = rdata_q;
    assign pmem_resp  = (state_q == PMEM_RESP);

`ifdef PMEM_PROTOCOL_CHECK_EN
    logic        err_q, err_d;
    logic [15:0] addr_q, addr_d;

    always_comb begin
        err_d  = err_q;
        addr_d = addr_q;
        if (state_q == PMEM_IDLE && req) begin
            addr_d = pmem_address;
        end
        if (pmem_read && pmem_write) begin
            err_d = 1'b1;
        end
        if ((state_q == PMEM_BURST || state_q == PMEM_DRAIN || state_q == PMEM_WAIT) && !req) begin
            err_d = 1'b1;
        end
        if (state_q != PMEM_IDLE && req && (pmem_address != addr_q || pmem_write != op_wr_q)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q  <= 1'b0;
            addr_q <= 16'd0;
        end else begin
            err_q  <= err_d;
            addr_q <= addr_d;
        end
    end

    assign pmem_err = err_q;
`else
    assign pmem_err = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_line_responder.sv
// Self-checking bench: three responder configurations against a line-level memory model.
module tb_pmem_line_responder;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rd   [3];
    logic          wr   [3];
    logic [15:0]   addr [3];
    logic [127:0]  wd   [3];
    logic [127:0]  rdata0, rdata1, rdata2;
    logic          resp0, resp1, resp2;
    logic          err0, err1, err2;
    logic [127:0]  rdata_a [3];
    logic          resp_a  [3];
    logic          err_a   [3];

    int            lat   [3] = '{10, 0, 255};
    int            depth [3] = '{4096, 256, 16};
    logic [127:0]  mem_m [int];
    logic [127:0]  exp_rd [3];
    int            cyc = 0;
    int            tests = 0;
    int            fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        rdata_a[0] = rdata0; rdata_a[1] = rdata1; rdata_a[2] = rdata2;
        resp_a[0]  = resp0;  resp_a[1]  = resp1;  resp_a[2]  = resp2;
        err_a[0]   = err0;   err_a[1]   = err1;   err_a[2]   = err2;
    end

    pmem_line_responder #(.LATENCY(10), .DEPTH_LINES(4096)) dut0 (
        .clk(clk), .rst_n(rst_n), .pmem_read(rd[0]), .pmem_write(wr[0]),
        .pmem_address(addr[0]), .pmem_wdata(wd[0]), .pmem_rdata(rdata0),
        .pmem_resp(resp0), .pmem_err(err0));

    pmem_line_responder #(.LATENCY(0), .DEPTH_LINES(256)) dut1 (
        .clk(clk), .rst_n(rst_n), .pmem_read(rd[1]), .pmem_write(wr[1]),
        .pmem_address(addr[1]), .pmem_wdata(wd[1]), .pmem_rdata(rdata1),
        .pmem_resp(resp1), .pmem_err(err1));

    pmem_line_responder #(.LATENCY(255), .DEPTH_LINES(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .pmem_read(rd[2]), .pmem_write(wr[2]),
        .pmem_address(addr[2]), .pmem_wdata(wd[2]), .pmem_rdata(rdata2),
        .pmem_resp(resp2), .pmem_err(err2));

    function automatic int line_key(input int d, input logic [15:0] a);
        return d * 65536 + ((int'(a) >> 4) % depth[d]);
    endfunction

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Entered and left at #1 after a rising edge; leaves one cycle after RESP.
    task automatic txn(input int d, input bit is_rd, input bit is_wr,
                       input logic [15:0] a, input logic [127:0] w, output int resp_cyc);
        int  n;
        bit  got;
        int  k;
        n = 0;
        got = 0;
        rd[d] = is_rd; wr[d] = is_wr; addr[d] = a; wd[d] = w;
        while (!got && n < 400) begin
            @(posedge clk); #1;
            n++;
            if (resp_a[d] === 1'b1) got = 1;
        end
        rd[d] = 1'b0; wr[d] = 1'b0;
        resp_cyc = cyc;
        k = line_key(d, a);
        if (is_wr) mem_m[k] = w;
        else if (mem_m.exists(k)) exp_rd[d] = mem_m[k];
        tests++;
        if (!got || n != 10 + lat[d]) begin
            fails++;
            $display("FAIL latency dut%0d addr=%h: resp cycle %0d (seen=%0d), expected %0d", d, a, n, got, 10 + lat[d]);
        end
        tests++;
        if (rdata_a[d] !== exp_rd[d]) begin
            fails++;
            $display("FAIL rdata dut%0d addr=%h: got %h expected %h", d, a, rdata_a[d], exp_rd[d]);
        end
        @(posedge clk); #1;
        tests++;
        if (resp_a[d] !== 1'b0) begin
            fails++;
            $display("FAIL resp_width dut%0d: resp=%b one cycle after pulse, expected 0", d, resp_a[d]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = 16'd0; wd[d] = '0; exp_rd[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            tests++;
            if (resp_a[d] !== 1'b0 || rdata_a[d] !== '0 || err_a[d] !== 1'b0) begin
                fails++;
                $display("FAIL reset dut%0d: resp=%b rdata=%h err=%b, expected 0/0/0", d, resp_a[d], rdata_a[d], err_a[d]);
            end
        end
    endtask

    task automatic test_write_read();
        int c;
        txn(0, 0, 1, 16'h1230, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, c);
        txn(0, 1, 0, 16'h1230, '0, c);
        tests++;
        if (rdata0 !== 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210) begin
            fails++;
            $display("FAIL known_line: got %h", rdata0);
        end
    endtask

    task automatic test_back_to_back();
        int c1, c2;
        txn(0, 1, 0, 16'h1230, '0, c1);
        txn(0, 0, 1, 16'h5670, rand_line(), c2);
        tests++;
        if (c2 - c1 != 21) begin
            fails++;
            $display("FAIL b2b_gap: got %0d cycles, expected 21", c2 - c1);
        end
        txn(0, 1, 0, 16'h5670, '0, c1);
    endtask

    task automatic test_random();
        logic [15:0] written[$];
        logic [15:0] a;
        int c;
        for (int i = 0; i < 16; i++) begin
            if (written.size() == 0 || $urandom_range(1, 0) == 1) begin
                a = 16'($urandom);
                written.push_back(a);
                txn(0, 0, 1, a, rand_line(), c);
            end else begin
                a = written[$urandom_range(written.size() - 1, 0)];
                a[3:0] = 4'($urandom);
                txn(0, 1, 0, a, '0, c);
            end
        end
    endtask

    task automatic test_alias_lat0();
        int c;
        logic [127:0] line;
        line = rand_line();
        txn(1, 0, 1, 16'h1000, line, c);
        txn(1, 1, 0, 16'h100F, '0, c);
        tests++;
        if (rdata1 !== line) begin
            fails++;
            $display("FAIL alias_low: got %h expected %h", rdata1, line);
        end
        txn(1, 1, 0, 16'h2000, '0, c);
        tests++;
        if (rdata1 !== line) begin
            fails++;
            $display("FAIL alias_wrap: got %h expected %h", rdata1, line);
        end
        txn(1, 0, 1, 16'h0040, rand_line(), c);
        txn(1, 1, 0, 16'h0040, '0, c);
    endtask

    task automatic test_lat255();
        int c;
        txn(2, 0, 1, 16'h0040, rand_line(), c);
        txn(2, 1, 0, 16'h0040, '0, c);
    endtask

    task automatic test_both_rw();
        int c;
        bit exp_err;
`ifdef PMEM_PROTOCOL_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        tests++;
        if (err0 !== 1'b0) begin
            fails++;
            $display("FAIL err_clean: err=%b before violation, expected 0", err0);
        end
        txn(0, 1, 1, 16'h0300, rand_line(), c);
        txn(0, 1, 0, 16'h0300, '0, c);
        tests++;
        if (err0 !== exp_err) begin
            fails++;
            $display("FAIL err_sticky: err=%b expected %b", err0, exp_err);
        end
    endtask

    task automatic test_midreset();
        int c;
        int k;
        bit seen;
        logic [127:0] oldl, newl, mix;
        oldl = rand_line();
        newl = rand_line();
        txn(0, 0, 1, 16'h0200, oldl, c);
        seen = 0;
        rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 16'h0200; wd[0] = newl;
        repeat (5) begin
            @(posedge clk); #1;
            if (resp0 === 1'b1) seen = 1;
        end
        rst_n = 1'b0;
        wr[0] = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (resp0 === 1'b1) seen = 1;
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (resp0 === 1'b1) seen = 1;
        end
        tests++;
        if (seen) begin
            fails++;
            $display("FAIL midreset_resp: resp pulsed for aborted write");
        end
        tests++;
        if (rdata0 !== '0 || err0 !== 1'b0) begin
            fails++;
            $display("FAIL midreset_state: rdata=%h err=%b expected 0/0", rdata0, err0);
        end
        for (int d = 0; d < 3; d++) exp_rd[d] = '0;
        mix = {oldl[127:64], newl[63:0]};
        k = line_key(0, 16'h0200);
        mem_m[k] = mix;
        txn(0, 1, 0, 16'h0200, '0, c);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_random();
        test_alias_lat0();
        test_lat255();
        test_both_rw();
        test_midreset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pmem_line_responder.md
# pmem_line_responder

Synthesizable physical-memory responder that sits on the far side of the L2 cache's pmem interface. It accepts one 128-bit line read or write at a time and services it as eight 16-bit beats against an internal word-wide storage array. After a programmable extra latency it returns exactly one `pmem_resp` pulse. It replaces the behavioral memory model, so the L2 miss, write-back and fetch paths run against cycle-accurate memory timing in both simulation and FPGA builds.

## Interface
- `LATENCY`, default 10: extra wait cycles after the beat phase; range 0–255.
- `DEPTH_LINES`, default 4096: number of 128-bit lines stored; must be a power of 2, at most 4096.
- `clk` in 1: the single clock; all state changes on rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `pmem_read` in 1: line read request, level-held by the initiator until `pmem_resp`.
- `pmem_write` in 1: line write request, level-held by the initiator until `pmem_resp`.
- `pmem_address` in 16: byte address; bits [3:0] ignored; line index = `pmem_address[4 +: log2(DEPTH_LINES)]`.
- `pmem_wdata` in 128: write line; word k = bits [16k+15:16k].
- `pmem_rdata` out 128: read line, registered.
- `pmem_resp` out 1: single-cycle completion pulse.
- `pmem_err` out 1: sticky protocol-error flag; see Configuration.

## Operation
- FSM states: IDLE, BURST, DRAIN, WAIT, RESP.
- IDLE:
  - If `pmem_read | pmem_write` is high at a rising edge: latch the line index, the operation and `pmem_wdata`, clear the beat counter, and go to BURST.
  - If both read and write are high, write wins.
- BURST, 8 cycles, beat counter k = 0..7:
  - Write: store latched word k to array address {index, k}.
  - Read: issue a read of {index, k}. Array data returns one cycle later and is packed into word k of an internal assembly register.
  - Leave BURST after k = 7.
- DRAIN, 1 cycle: captures read word 7; a write does nothing.
  - If LATENCY = 0, go to RESP; otherwise go to WAIT with the counter loaded to LATENCY − 1.
- WAIT: count down to 0, then go to RESP.
- RESP, 1 cycle:
  - `pmem_resp` = 1.
  - For a read, `pmem_rdata` loads the assembled line at the edge entering RESP.
  - Always return to IDLE; the request is re-sampled only from IDLE.
- `pmem_rdata` holds its value until the next read's RESP. Writes never change it.
- Inputs are ignored outside IDLE. A request deasserted mid-transaction still completes and still pulses `pmem_resp`.
- Address wrap: index bits above log2(DEPTH_LINES) are discarded, so line addresses alias modulo DEPTH_LINES.

## Timing
- With the request first high in cycle 0, `pmem_resp` is high in cycle 10 + LATENCY. Default LATENCY = 10 gives cycle 20.
- Back-to-back requests (write-back then fetch): a request held high in the cycle after RESP is accepted at that edge with no bubble. Successive `pmem_resp` pulses are 11 + LATENCY cycles apart.
- Reset values: state IDLE, `pmem_resp` 0, `pmem_rdata` 0, `pmem_err` 0, counters 0.
- Array contents are not reset.
- Reset asserted mid-transaction: immediate return to IDLE with no response. A partially written line keeps the beats already stored.

## Configuration
- `PMEM_PROTOCOL_CHECK_EN` defined: `pmem_err` sets, and stays set until reset, on any of:
  - `pmem_read & pmem_write` in any cycle;
  - a request dropping in BURST, DRAIN or WAIT;
  - `pmem_address` or the operation changing while a request is high outside IDLE.
- Undefined: `pmem_err` is tied to 0 and no checker logic is built.
- Functional behavior is identical either way.

## Structure
- Add to `lc3b_types`:
  - typedef `lc3b_pmem_line` (logic [127:0]);
  - constant `PMEM_BEATS` = 8;
  - enum type for the FSM states.
- Sub-module `pmem_word_array`:
  - single-port, 16-bit wide, `DEPTH_LINES*8` deep;
  - synchronous write;
  - read data registered with one-cycle latency.
- The FSM, counters, assembly register and checker live in the top module.

## Test plan
- Write 0x0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 to 0x1230, then read 0x1230 → `pmem_resp` in cycle 20 of each transaction; `pmem_rdata` equals the written line.
- Read 0x1230 immediately followed by a write to 0x5670 held from the cycle after RESP → the second `pmem_resp` comes exactly 21 cycles after the first; `pmem_rdata` is unchanged by the write.
- LATENCY = 0, read of 0x0040 → `pmem_resp` in cycle 10; LATENCY = 255 → cycle 265.
- Write to 0x1000, then read 0x100F and, with DEPTH_LINES = 256, read 0x2000 → both return the same line (low-bit ignore, index aliasing).
- Assert `rst_n` = 0 in beat 4 of a write to 0x0200 → `pmem_resp` never pulses; after release, a read of 0x0200 returns new words 0–3 and old words 4–7.
- With `PMEM_PROTOCOL_CHECK_EN`, drive read and write together to 0x0300 → the write is performed and `pmem_err` = 1 until reset. Without the macro → `pmem_err` stays 0.
